// File: rtl/press_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : press_cursor_ctrl
// Purpose  : Board cursor driven by debounced button pulses, plus a small
//            show-ahead FIFO of centre-press "select" coordinates handed to
//            the game side over a valid/ready handshake.
//            Macro PRESS_CURSOR_WRAP_EN: cursor wraps toroidally at the board
//            edges instead of saturating.
// Revision : 1.0 - initial release
// ============================================================================
module press_cursor_ctrl #(
    parameter int BOARD_SIZE = 19,
    parameter int COORD_W    = 5,
    parameter int FIFO_AW    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    input  logic               i_center,
    output logic [COORD_W-1:0] o_cur_x,
    output logic [COORD_W-1:0] o_cur_y,
    output logic               o_sel_valid,
    output logic [COORD_W-1:0] o_sel_x,
    output logic [COORD_W-1:0] o_sel_y,
    input  logic               i_sel_ready,
    output logic [FIFO_AW:0]   o_sel_count,
    output logic               o_drop
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [COORD_W-1:0] c_max = COORD_W'(BOARD_SIZE - 1);
    localparam logic [COORD_W-1:0] c_mid = COORD_W'((BOARD_SIZE - 1) / 2);
    localparam logic [FIFO_AW:0]   c_full = {1'b1, {FIFO_AW{1'b0}}};

`ifdef PRESS_CURSOR_WRAP_EN
    // Value a coordinate takes when stepping past the low / high edge.
    localparam logic [COORD_W-1:0] c_below_lo = c_max;
    localparam logic [COORD_W-1:0] c_above_hi = '0;
`else
    localparam logic [COORD_W-1:0] c_below_lo = '0;
    localparam logic [COORD_W-1:0] c_above_hi = c_max;
`endif

    // One axis step: opposite presses cancel, edges saturate or wrap.
    function automatic logic [COORD_W-1:0] f_step(
        input logic [COORD_W-1:0] cur,
        input logic               dec,
        input logic               inc
    );
        logic [COORD_W-1:0] res;
        res = cur;
        if (dec && !inc) begin
            if (cur == '0)
                res = c_below_lo;
            else
                res = cur - 1'b1;
        end else if (inc && !dec) begin
            if (cur >= c_max)
                res = c_above_hi;
            else
                res = cur + 1'b1;
        end
        return res;
    endfunction

    logic [COORD_W-1:0] r_cur_x;
    logic [COORD_W-1:0] r_cur_y;

    logic [COORD_W-1:0] r_mem_x [DEPTH];
    logic [COORD_W-1:0] r_mem_y [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [COORD_W-1:0] r_sel_x;
    logic [COORD_W-1:0] r_sel_y;
    logic               r_drop;

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic [FIFO_AW-1:0] w_rd_next;
    logic [FIFO_AW:0]   w_count_next;
    logic [COORD_W-1:0] w_head_x;
    logic [COORD_W-1:0] w_head_y;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == c_full);
    assign w_pop     = w_valid && i_sel_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push    = i_center && (!w_full || w_pop);
    assign w_rd_next = r_rd_ptr + 1'b1;

    // Next occupancy and next head value for the show-ahead output registers.
    always_comb begin
        w_count_next = r_count;
        w_head_x     = r_sel_x;
        w_head_y     = r_sel_y;
        if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_next = r_count - 1'b1;

        if (w_pop) begin
            if (r_count > 1) begin
                w_head_x = r_mem_x[w_rd_next];
                w_head_y = r_mem_y[w_rd_next];
            end else if (w_push) begin
                w_head_x = r_cur_x;
                w_head_y = r_cur_y;
            end
        end else if (!w_valid && w_push) begin
            w_head_x = r_cur_x;
            w_head_y = r_cur_y;
        end
    end

    // Cursor register; the two axes move independently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_x <= c_mid;
            r_cur_y <= c_mid;
        end else begin
            r_cur_x <= f_step(r_cur_x, i_left, i_right);
            r_cur_y <= f_step(r_cur_y, i_up, i_down);
        end
    end

    // FIFO storage; captures the cursor as it stood before this edge.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= r_cur_x;
            r_mem_y[r_wr_ptr] <= r_cur_y;
        end
    end

    // FIFO pointers, occupancy, head registers and drop pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sel_x  <= '0;
            r_sel_y  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= w_rd_next;
            r_count <= w_count_next;
            r_sel_x <= w_head_x;
            r_sel_y <= w_head_y;
            r_drop  <= i_center && w_full && !w_pop;
        end
    end

    assign o_cur_x     = r_cur_x;
    assign o_cur_y     = r_cur_y;
    assign o_sel_valid = w_valid;
    assign o_sel_x     = r_sel_x;
    assign o_sel_y     = r_sel_y;
    assign o_sel_count = r_count;
    assign o_drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_press_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_press_cursor_ctrl
// Purpose  : Self-checking bench for press_cursor_ctrl: queue-based reference
//            model compared every cycle plus hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_press_cursor_ctrl;

    localparam int N = 19;

`ifdef PRESS_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_up = 0, i_down = 0, i_left = 0, i_right = 0, i_center = 0;
    logic       i_sel_ready = 0;
    logic [4:0] o_cur_x, o_cur_y, o_sel_x, o_sel_y;
    logic       o_sel_valid, o_drop;
    logic [2:0] o_sel_count;

    int n_vec = 0;
    int n_err = 0;

    press_cursor_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_center(i_center),
        .o_cur_x(o_cur_x), .o_cur_y(o_cur_y),
        .o_sel_valid(o_sel_valid), .o_sel_x(o_sel_x), .o_sel_y(o_sel_y),
        .i_sel_ready(i_sel_ready), .o_sel_count(o_sel_count), .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    int m_x, m_y, m_hx, m_hy;
    int qx[$];
    int qy[$];
    bit m_drop;

    function automatic int axis(input int v, input bit dec, input bit inc);
        if (dec == inc) return v;
        if (dec) return (v == 0) ? (WRAP ? N - 1 : 0) : v - 1;
        return (v == N - 1) ? (WRAP ? 0 : N - 1) : v + 1;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_x = (N - 1) / 2; m_y = (N - 1) / 2;
            qx.delete(); qy.delete();
            m_drop = 0; m_hx = 0; m_hy = 0;
        end else begin
            int cx, cy;
            cx = m_x; cy = m_y;
            m_drop = 0;
            if (qx.size() != 0 && i_sel_ready) begin
                void'(qx.pop_front()); void'(qy.pop_front());
            end
            if (i_center) begin
                if (qx.size() < 4) begin qx.push_back(cx); qy.push_back(cy); end
                else m_drop = 1;
            end
            m_x = axis(cx, i_left, i_right);
            m_y = axis(cy, i_up, i_down);
            if (qx.size() != 0) begin m_hx = qx[0]; m_hy = qy[0]; end
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("cur_x", int'(o_cur_x), m_x);
            chk("cur_y", int'(o_cur_y), m_y);
            chk("count", int'(o_sel_count), qx.size());
            chk("valid", int'(o_sel_valid), int'(qx.size() != 0));
            chk("drop", int'(o_drop), int'(m_drop));
            if (qx.size() != 0) begin
                chk("sel_x", int'(o_sel_x), m_hx);
                chk("sel_y", int'(o_sel_y), m_hy);
            end
        end
    end

    // Apply one cycle of inputs {up,down,left,right,center,ready}; returns at negedge.
    task automatic step(input logic [5:0] v);
        {i_up, i_down, i_left, i_right, i_center, i_sel_ready} = v;
        @(posedge i_clk);
        @(negedge i_clk);
        {i_up, i_down, i_left, i_right, i_center, i_sel_ready} = 6'b0;
    endtask

    task automatic repeat_step(input logic [5:0] v, input int n);
        for (int k = 0; k < n; k++) step(v);
    endtask

    localparam logic [5:0] UP = 6'b100000, DN = 6'b010000, LF = 6'b001000,
                           RT = 6'b000100, CT = 6'b000010, RD = 6'b000001,
                           IDLE = 6'b000000;

    logic [5:0] mix [16] = '{RT|CT, CT, CT|RD, LF|RT, UP|DN|CT, DN, RD, CT|LF,
                              CT|RD|UP, CT, CT, CT, CT|RD, RD, RD, RT|DN|CT|RD};

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_cur_x", int'(o_cur_x), 9);
        chk("rst_cur_y", int'(o_cur_y), 9);
        chk("rst_count", int'(o_sel_count), 0);
        chk("rst_valid", int'(o_sel_valid), 0);
        chk("rst_drop", int'(o_drop), 0);
        chk("rst_sel_x", int'(o_sel_x), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Basic moves
        repeat_step(RT, 3);
        repeat_step(UP, 2);
        chk("move_x", int'(o_cur_x), 12);
        chk("move_y", int'(o_cur_y), 7);
        chk("move_valid", int'(o_sel_valid), 0);

        // Edge behaviour
        repeat_step(LF, 12);
        chk("at_x0", int'(o_cur_x), 0);
        step(LF);
        chk("edge_left", int'(o_cur_x), WRAP ? 18 : 0);
        repeat_step(DN, 11);
        chk("at_y18", int'(o_cur_y), 18);
        step(DN);
        chk("edge_down", int'(o_cur_y), WRAP ? 0 : 18);

        // Capture with simultaneous move
        i_rst_n = 1'b0; @(negedge i_clk); i_rst_n = 1'b1; @(negedge i_clk);
        step(CT | RT);
        chk("cap_valid", int'(o_sel_valid), 1);
        chk("cap_hx", int'(o_sel_x), 9);
        chk("cap_hy", int'(o_sel_y), 9);
        chk("cap_cur_x", int'(o_cur_x), 10);
        chk("cap_count", int'(o_sel_count), 1);
        step(RD);
        chk("cap_popped", int'(o_sel_valid), 0);

        // Overflow: five selects into a four-entry FIFO
        repeat_step(LF, 9);
        repeat_step(UP, 8);
        repeat_step(CT | RT, 4);
        chk("fill_drop", int'(o_drop), 0);
        step(CT | RT);
        chk("ovf_drop", int'(o_drop), 1);
        chk("ovf_count", int'(o_sel_count), 4);
        step(IDLE);
        chk("drop_pulse", int'(o_drop), 0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_hx", int'(o_sel_x), i);
            chk("drain_hy", int'(o_sel_y), 1);
            step(RD);
        end
        chk("drain_valid", int'(o_sel_valid), 0);

        // Push and pop together while full
        repeat_step(CT, 4);
        step(RT);
        step(CT | RD);
        chk("fullpp_drop", int'(o_drop), 0);
        chk("fullpp_count", int'(o_sel_count), 4);
        repeat_step(RD, 3);
        chk("tail_hx", int'(o_sel_x), 7);
        step(RD);
        chk("tail_empty", int'(o_sel_count), 0);

        // Opposite presses cancel, then asynchronous mid-cycle reset
        step(LF | RT | UP);
        chk("cancel_x", int'(o_cur_x), 7);
        chk("cancel_y", int'(o_cur_y), 0);
        repeat_step(CT, 2);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_x", int'(o_cur_x), 9);
        chk("async_y", int'(o_cur_y), 9);
        chk("async_count", int'(o_sel_count), 0);
        chk("async_valid", int'(o_sel_valid), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Mixed directed patterns, model-checked each cycle
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 16; i++) step(mix[i]);
        repeat_step(RD, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
